// File: rtl/fsm_tile_ctrl.sv
// Master layer sequencer for the DLA controller: FSLD, LEFT, BASE x N, RIGHT, DONE.
// Supports a runtime tile count, a tile index, a phase-entry strobe and a synchronous abort.
module fsm_tile_ctrl #(
    parameter int MAST_FSM_BITS = 3,
    parameter int TILE_BITS     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [TILE_BITS-1:0]     cfg_num_tile,
    input  logic                     flag_fsld_end,
    input  logic                     left_done,
    input  logic                     base_done,
    input  logic                     right_done,
    output logic [MAST_FSM_BITS-1:0] outmast_curr_state,
    output logic [TILE_BITS-1:0]     tile_idx,
    output logic                     phase_start,
    output logic                     busy,
    output logic                     layer_done
);

    typedef enum logic [MAST_FSM_BITS-1:0] {
        M_IDLE = MAST_FSM_BITS'(0),
        LEFT   = MAST_FSM_BITS'(1),
        BASE   = MAST_FSM_BITS'(2),
        RIGHT  = MAST_FSM_BITS'(3),
        DONE   = MAST_FSM_BITS'(4),
        FSLD   = MAST_FSM_BITS'(7)
    } state_t;

    localparam logic [TILE_BITS-1:0] ONE = TILE_BITS'(1);
    localparam logic [TILE_BITS-1:0] TWO = TILE_BITS'(2);

    state_t               state;
    logic [TILE_BITS-1:0] num_tile_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= M_IDLE;
            tile_idx    <= '0;
            num_tile_r  <= '0;
            phase_start <= 1'b0;
        end else begin
            phase_start <= 1'b0;
            if (abort && state != M_IDLE) begin
                state    <= M_IDLE;
                tile_idx <= '0;
            end else begin
                case (state)
                    M_IDLE: begin
                        // abort in idle also masks a coincident start
                        if (start && !abort) begin
                            num_tile_r <= (cfg_num_tile == '0) ? ONE : cfg_num_tile;
                            tile_idx   <= '0;
                            state      <= FSLD;
                        end
                    end
                    FSLD: begin
                        if (flag_fsld_end) begin
                            state       <= LEFT;
                            tile_idx    <= '0;
                            phase_start <= 1'b1;
                        end
                    end
                    LEFT: begin
                        if (left_done) begin
                            if (num_tile_r == ONE) begin
                                state <= DONE;
                            end else begin
                                state       <= (num_tile_r == TWO) ? RIGHT : BASE;
                                tile_idx    <= ONE;
                                phase_start <= 1'b1;
                            end
                        end
                    end
                    BASE: begin
                        if (base_done) begin
                            phase_start <= 1'b1;
                            if (tile_idx == num_tile_r - TWO) begin
                                state    <= RIGHT;
                                tile_idx <= num_tile_r - ONE;
                            end else begin
                                tile_idx <= tile_idx + ONE;
                            end
                        end
                    end
                    RIGHT: begin
                        if (right_done) state <= DONE;
                    end
                    DONE: begin
                        state <= M_IDLE;
                    end
                    default: begin
                        state <= M_IDLE;
                    end
                endcase
            end
        end
    end

    assign outmast_curr_state = state;
    assign busy               = (state != M_IDLE);
    assign layer_done         = (state == DONE);

endmodule

// File: tb/tb_fsm_tile_ctrl.sv
// Directed bench for fsm_tile_ctrl: full layers, degenerate tile counts, spurious flags,
// abort, reset and a narrow-index build with the maximum tile count.
module tb_fsm_tile_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, start_b, abort;
    logic       flag_fsld_end, left_done, base_done, right_done;
    logic [7:0] cfg_num_tile;
    logic [3:0] cfg_num_tile_b;

    logic [2:0] state_a, state_b;
    logic [7:0] tile_a;
    logic [3:0] tile_b;
    logic       ps_a, busy_a, ld_a, ps_b, busy_b, ld_b;

    int errors = 0;
    int checks = 0;
    int ps_cnt = 0;
    int ld_cnt = 0;

    always #5 clk = ~clk;

    fsm_tile_ctrl #(.MAST_FSM_BITS(3), .TILE_BITS(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_num_tile(cfg_num_tile), .flag_fsld_end(flag_fsld_end),
        .left_done(left_done), .base_done(base_done), .right_done(right_done),
        .outmast_curr_state(state_a), .tile_idx(tile_a), .phase_start(ps_a),
        .busy(busy_a), .layer_done(ld_a)
    );

    fsm_tile_ctrl #(.MAST_FSM_BITS(3), .TILE_BITS(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort),
        .cfg_num_tile(cfg_num_tile_b), .flag_fsld_end(flag_fsld_end),
        .left_done(left_done), .base_done(base_done), .right_done(right_done),
        .outmast_curr_state(state_b), .tile_idx(tile_b), .phase_start(ps_b),
        .busy(busy_b), .layer_done(ld_b)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ps_a) ps_cnt++;
        if (ld_a) ld_cnt++;
    endtask

    task automatic expect_a(input string tag, input int unsigned st, input int unsigned ti,
                            input int unsigned ps);
        chk({tag, ".state"}, 32'(state_a), st);
        chk({tag, ".tile"},  32'(tile_a), ti);
        chk({tag, ".pstart"}, 32'(ps_a), ps);
        chk({tag, ".busy"},  32'(busy_a), (st != 0) ? 1 : 0);
        chk({tag, ".ldone"}, 32'(ld_a), (st == 4) ? 1 : 0);
    endtask

    task automatic expect_b(input string tag, input int unsigned st, input int unsigned ti,
                            input int unsigned ps);
        chk({tag, ".state"}, 32'(state_b), st);
        chk({tag, ".tile"},  32'(tile_b), ti);
        chk({tag, ".pstart"}, 32'(ps_b), ps);
        chk({tag, ".ldone"}, 32'(ld_b), (st == 4) ? 1 : 0);
    endtask

    task automatic clear_inputs();
        start = 0; start_b = 0; abort = 0;
        flag_fsld_end = 0; left_done = 0; base_done = 0; right_done = 0;
    endtask

    // Launch a layer on the 8-bit instance and advance to the first LEFT cycle.
    task automatic to_left(input logic [7:0] n, input string tag);
        start = 1; cfg_num_tile = n;
        tick();
        start = 0;
        expect_a({tag, ".fsld"}, 7, 0, 0);
        flag_fsld_end = 1;
        tick();
        flag_fsld_end = 0;
        expect_a({tag, ".left"}, 1, 0, 1);
    endtask

    initial begin
        clear_inputs();
        reset = 1; cfg_num_tile = '0; cfg_num_tile_b = '0;
        tick(); tick();
        expect_a("rst", 0, 0, 0);
        reset = 0;
        tick();
        expect_a("idle", 0, 0, 0);

        // Five-tile layer
        ps_cnt = 0; ld_cnt = 0;
        to_left(8'd5, "n5");
        cfg_num_tile = 8'd9;
        tick();
        expect_a("n5.left_hold", 1, 0, 0);
        left_done = 1;
        tick();
        left_done = 0;
        expect_a("n5.base1", 2, 1, 1);
        base_done = 1;
        tick(); expect_a("n5.base2", 2, 2, 1);
        tick(); expect_a("n5.base3", 2, 3, 1);
        tick(); expect_a("n5.right", 3, 4, 1);
        base_done = 0;
        tick(); expect_a("n5.right_hold", 3, 4, 0);
        right_done = 1;
        tick(); right_done = 0;
        expect_a("n5.done", 4, 4, 0);
        tick(); expect_a("n5.idle", 0, 4, 0);
        tick(); expect_a("n5.idle2", 0, 4, 0);
        chk("n5.pstart_count", ps_cnt, 5);
        chk("n5.ldone_count", ld_cnt, 1);

        // Reset mid-BASE at tile 2
        ld_cnt = 0;
        to_left(8'd5, "rstb");
        left_done = 1; tick(); left_done = 0;
        base_done = 1; tick(); base_done = 0;
        expect_a("rstb.base2", 2, 2, 1);
        reset = 1; tick(); reset = 0;
        expect_a("rstb.after", 0, 0, 0);
        chk("rstb.ldone_count", ld_cnt, 0);

        // Degenerate counts: 1 and 0 go LEFT -> DONE
        to_left(8'd1, "n1");
        left_done = 1; tick(); left_done = 0;
        expect_a("n1.done", 4, 0, 0);
        tick(); expect_a("n1.idle", 0, 0, 0);
        to_left(8'd0, "n0");
        left_done = 1; tick(); left_done = 0;
        expect_a("n0.done", 4, 0, 0);
        tick(); expect_a("n0.idle", 0, 0, 0);

        // Two tiles: LEFT -> RIGHT, BASE skipped
        to_left(8'd2, "n2");
        left_done = 1; tick(); left_done = 0;
        expect_a("n2.right", 3, 1, 1);
        right_done = 1; tick(); right_done = 0;
        expect_a("n2.done", 4, 1, 0);
        tick(); expect_a("n2.idle", 0, 1, 0);

        // Spurious flags, start in BASE, abort in RIGHT
        ld_cnt = 0;
        start = 1; cfg_num_tile = 8'd3;
        tick(); start = 0;
        expect_a("sp.fsld", 7, 0, 0);
        base_done = 1; right_done = 1;
        tick(); expect_a("sp.fsld_hold", 7, 0, 0);
        flag_fsld_end = 1;
        tick(); flag_fsld_end = 0;
        expect_a("sp.left", 1, 0, 1);
        tick(); expect_a("sp.left_hold", 1, 0, 0);
        base_done = 0; right_done = 0;
        left_done = 1; tick(); left_done = 0;
        expect_a("sp.base1", 2, 1, 1);
        start = 1; cfg_num_tile = 8'd9;
        tick(); start = 0;
        expect_a("sp.base_start", 2, 1, 0);
        base_done = 1; tick(); base_done = 0;
        expect_a("sp.right", 3, 2, 1);
        abort = 1; tick(); abort = 0;
        expect_a("sp.abort", 0, 0, 0);
        tick(); expect_a("sp.abort_idle", 0, 0, 0);
        chk("sp.ldone_count", ld_cnt, 0);
        start = 1; cfg_num_tile = 8'd4;
        tick(); start = 0;
        expect_a("sp.restart", 7, 0, 0);

        // abort in FSLD, then abort+start together in idle
        abort = 1; tick(); abort = 0;
        expect_a("ab.fsld", 0, 0, 0);
        abort = 1; start = 1;
        tick(); abort = 0; start = 0;
        expect_a("ab.idle_start", 0, 0, 0);

        // Four-bit index build, maximum layer of 15 tiles
        ld_cnt = 0;
        start_b = 1; cfg_num_tile_b = 4'd15;
        tick(); start_b = 0;
        expect_b("w4.fsld", 7, 0, 0);
        flag_fsld_end = 1; tick(); flag_fsld_end = 0;
        expect_b("w4.left", 1, 0, 1);
        left_done = 1; tick(); left_done = 0;
        expect_b("w4.base1", 2, 1, 1);
        base_done = 1;
        for (int i = 2; i <= 13; i++) begin
            tick();
            expect_b($sformatf("w4.base%0d", i), 2, i, 1);
        end
        tick(); base_done = 0;
        expect_b("w4.right", 3, 14, 1);
        right_done = 1; tick(); right_done = 0;
        expect_b("w4.done", 4, 14, 0);
        tick(); expect_b("w4.idle", 0, 14, 0);
        chk("w4.other_idle", 32'(state_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsm_tile_ctrl.md
Name: fsm_tile_ctrl

Overview:
- Parametrised master FSM for the 64-MAC DLA main controller; sequences one layer as first-load (FSLD), then LEFT, BASE×N, RIGHT column tiles, then DONE.
- Adds what the two-phase FSLD/LEFT controller lacks:
  - runtime tile count
  - BASE/RIGHT phases
  - tile index, phase-entry strobe, busy, layer-done pulse
  - synchronous abort
- Sits between the top-level start/config registers and the per-phase datapath controllers, which return the *_done flags.

Parameters:
- MAST_FSM_BITS, 3: state register width. Encoding fixed:
  - M_IDLE=0, LEFT=1, BASE=2, RIGHT=3, DONE=4, FSLD=7
  - 5, 6 unused
- TILE_BITS, 8: width of tile count and tile index.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  layer start request; sampled only in M_IDLE
- abort  input  1  synchronous abort; highest priority after reset
- cfg_num_tile  input  TILE_BITS  column tiles in layer; sampled with start
- flag_fsld_end  input  1  first sram0 load complete
- left_done  input  1  LEFT tile complete
- base_done  input  1  current BASE tile complete
- right_done  input  1  RIGHT tile complete
- outmast_curr_state  output  MAST_FSM_BITS  registered current state
- tile_idx  output  TILE_BITS  registered index of tile being processed
- phase_start  output  1  one-cycle pulse on first cycle of LEFT/BASE/RIGHT (each BASE tile)
- busy  output  1  high whenever state != M_IDLE
- layer_done  output  1  one-cycle pulse, high exactly while in DONE

Behaviour:
- Reset and register style:
  - Every state transition is registered on posedge clk.
  - reset=1 forces state=M_IDLE, tile_idx=0, num_tile_r=0, phase_start=0 on the next edge.
  - Combinational outputs (busy, layer_done) follow: busy=0, layer_done=0.
- Start and configuration:
  - M_IDLE: start=1 latches num_tile_r = (cfg_num_tile==0) ? 1 : cfg_num_tile, clears tile_idx=0, goes to FSLD.
  - start outside M_IDLE is ignored. cfg_num_tile changes after latch are ignored.
- FSLD: flag_fsld_end=1 -> LEFT, with tile_idx=0 and phase_start=1 in the first LEFT cycle.
- LEFT: left_done=1 ->
  - num_tile_r==1: DONE
  - num_tile_r==2: RIGHT, tile_idx=1
  - otherwise: BASE, tile_idx=1
- BASE: base_done=1 ->
  - tile_idx == num_tile_r-2: RIGHT, tile_idx=num_tile_r-1
  - otherwise: stay in BASE, tile_idx+1, phase_start=1 next cycle
- RIGHT: right_done=1 -> DONE.
- DONE: lasts exactly one cycle (layer_done=1), then M_IDLE. tile_idx holds its last value until the next start.
- Done-flag rules:
  - Each *_done / flag_fsld_end is honoured only in its own state; elsewhere it is ignored.
  - Multiple done flags high together: only the one matching the current state acts.
- phase_start:
  - Registered; asserted in the cycle after any transition into LEFT, BASE or RIGHT, and after a BASE->BASE tile advance.
  - Never asserted in M_IDLE/FSLD/DONE.
- abort:
  - abort=1 in any state != M_IDLE -> M_IDLE next edge, tile_idx=0, phase_start=0, no layer_done pulse.
  - abort in M_IDLE: no effect, and start in the same cycle is ignored.
- Illegal states (5, 6) -> M_IDLE next edge.
- tile_idx arithmetic is unsigned modulo 2^TILE_BITS. The maximum layer is num_tile_r = 2^TILE_BITS-1; the index never wraps in legal operation.
- Latency: start to FSLD is 1 cycle. Every done flag to the next state is 1 cycle.

Test Plan:
- Reset mid-BASE (num_tile=5, tile_idx=2), assert reset 1 cycle -> state=0, tile_idx=0, busy=0, no layer_done.
- start with cfg_num_tile=5; pulse flag_fsld_end, left_done, then base_done ×3, then right_done:
  - state sequence 0,7,1,2,2,2,3,4,0
  - tile_idx 0,1,2,3,4
  - phase_start pulses 5 times
  - layer_done high exactly 1 cycle
- cfg_num_tile=1 and cfg_num_tile=0: after left_done -> DONE directly, with no BASE/RIGHT. cfg_num_tile=2: LEFT -> RIGHT with tile_idx=1, BASE never entered.
- Spurious flags, e.g. right_done and base_done held high during FSLD and LEFT -> no effect; start asserted while in BASE -> ignored, num_tile_r unchanged.
- abort in RIGHT (num_tile=3) -> M_IDLE next cycle, layer_done never asserted. A new start next cycle with cfg_num_tile=4 -> clean FSLD entry, tile_idx=0.
- TILE_BITS=4 build with cfg_num_tile=15 -> BASE tiles 1..13, RIGHT tile_idx=14, no wrap, layer_done pulse.
